// File: rtl/oam_dma.sv
// OAM DMA engine: snoops CPU writes to 0xFF46 and copies BYTE_COUNT bytes from
// page {page, 8'h00} into OAM through a one-cycle read/write pipeline.
module oam_dma #(
  parameter int BYTE_COUNT   = 160,
  parameter int SETUP_CYCLES = 1
) (
  input  logic        iClock,
  input  logic        iReset,
  input  logic        iCpuWe,
  input  logic [15:0] iCpuAddr,
  input  logic [7:0]  iCpuData,
  input  logic [7:0]  iDmaReadData,
  output logic        oDmaActive,
  output logic [15:0] oDmaReadAddr,
  output logic        oOamWe,
  output logic [7:0]  oOamAddr,
  output logic [7:0]  oOamData,
  output logic [7:0]  oDmaReg,
  output logic        oDone
);

  typedef enum logic [1:0] {IDLE, SETUP, XFER, DRAIN} state_e;

  localparam logic [8:0] LAST_IDX   = 9'(BYTE_COUNT - 1);
  localparam logic [3:0] SETUP_LOAD = (SETUP_CYCLES == 0) ? 4'd0 : 4'(SETUP_CYCLES - 1);

  state_e      state_q;
  logic [7:0]  page_q;
  logic [8:0]  idx_q;
  logic [8:0]  idx_d;
  logic [3:0]  setup_cnt_q;
  logic [7:0]  dma_reg_q;
  logic [15:0] rd_addr_q;
  logic        active_q;
  logic        oam_we_q;
  logic [7:0]  oam_addr_q;
  logic        done_q;
  logic        trigger;
  logic [7:0]  eff_page;

  // 0xE0-0xFF source pages are echo RAM; fold them onto 0xC0-0xDF.
  always_comb begin
    trigger  = iCpuWe && (iCpuAddr == 16'hFF46);
    eff_page = (iCpuData[7:5] == 3'b111) ? (iCpuData & 8'hDF) : iCpuData;
    idx_d    = idx_q + 9'd1;
  end

  // NOTE: every register here uses non-blocking assignment so all state
  // advances together on the edge regardless of statement order.
  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      state_q     <= IDLE;
      page_q      <= 8'h00;
      idx_q       <= 9'd0;
      setup_cnt_q <= 4'd0;
      dma_reg_q   <= 8'h00;
      rd_addr_q   <= 16'h0000;
      active_q    <= 1'b0;
      oam_we_q    <= 1'b0;
      oam_addr_q  <= 8'h00;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (trigger) begin
        // A trigger in any state restarts; the pending write and any done are dropped.
        dma_reg_q   <= iCpuData;
        page_q      <= eff_page;
        idx_q       <= 9'd0;
        setup_cnt_q <= SETUP_LOAD;
        active_q    <= 1'b1;
        oam_we_q    <= 1'b0;
        if (SETUP_CYCLES == 0) begin
          state_q   <= XFER;
          rd_addr_q <= {eff_page, 8'h00};
        end else begin
          state_q   <= SETUP;
        end
      end else begin
        unique case (state_q)
          IDLE: begin
            oam_we_q <= 1'b0;
          end
          SETUP: begin
            if (setup_cnt_q == 4'd0) begin
              state_q   <= XFER;
              rd_addr_q <= {page_q, 8'h00};
            end else begin
              setup_cnt_q <= setup_cnt_q - 4'd1;
            end
          end
          XFER: begin
            oam_we_q   <= 1'b1;
            oam_addr_q <= idx_q[7:0];
            idx_q      <= idx_d;
            // The read address stays on the last byte through DRAIN and IDLE.
            if (idx_q == LAST_IDX) begin
              state_q <= DRAIN;
            end else begin
              rd_addr_q <= {page_q, idx_d[7:0]};
            end
          end
          DRAIN: begin
            oam_we_q <= 1'b0;
            active_q <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign oDmaActive   = active_q;
  assign oDmaReadAddr = rd_addr_q;
  assign oOamWe       = oam_we_q;
  assign oOamAddr     = oam_addr_q;
  assign oOamData     = iDmaReadData;
  assign oDmaReg      = dma_reg_q;
  assign oDone        = done_q;

endmodule
